multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle MIPS main control unit. It replaces the single-cycle opcode decoder with a Moore FSM that sequences the shared-ALU, single-memory datapath through the steps FETCH → DECODE → execute → memory → writeback. Memory latency is parametrised: it can be an external ready handshake or a fixed wait count. It sits between the instruction register (IR) opcode field and the multi-cycle datapath muxes and enables.

## Interface
- `OP_W`, 6: opcode width.
- `ALUOP_W`, 4: ALUOp width.
- `ALUOP_ADD`, 4'b0010: ALUOp for add.
- `ALUOP_SUB`, 4'b0110: ALUOp for subtract.
- `ALUOP_RTYPE`, 4'b1000: ALUOp meaning "ALU control decodes funct".
- `USE_MEM_READY`, 1: 1 = memory states end on `MemReady`; 0 = memory states end after `MEM_LATENCY` cycles.
- `MEM_LATENCY`, 1: cycles per memory state when `USE_MEM_READY`=0; must be ≥1.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `Opcode` in OP_W: IR[31:26]. Sampled only in DECODE.
- `Zero` in 1: ALU zero flag. Used by the datapath with `PCWriteCond`; not used by the FSM.
- `MemReady` in 1: memory access complete this cycle. Ignored when `USE_MEM_READY`=0.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemToReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1: datapath controls.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUOp` out ALUOP_W: ALU operation select (see parameters).
- `IllegalOp` out 1: sticky trap flag.
- `State` out 4: current state encoding, for debug.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12.
  - Encodings 13–15 go to FETCH on the next edge.
- `mem_done`:
  - When `USE_MEM_READY`=1: equals `MemReady`.
  - When `USE_MEM_READY`=0: high when the internal wait counter equals `MEM_LATENCY`-1.
  - The counter clears on entry to each memory state (FETCH, MEMRD, MEMWR) and counts up while in that state.
  - Counter width is $clog2(MEM_LATENCY+1).
- Outputs are 0 unless listed for the current state.
- FETCH:
  - `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=ADD, `PCSource`=00.
  - `IRWrite`=`PCWrite`=`mem_done`. This is the only Mealy term.
  - Stays in FETCH until `mem_done`, then goes to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=ADD. Next state by `Opcode`:
  - 100011 (lw) and 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX.
  - Any other opcode → TRAP.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=ADD. Goes to MEMRD for lw, MEMWR for sw. The opcode is held in an internal register captured in DECODE.
- MEMRD: `MemRead`=1, `IorD`=1. Stays until `mem_done`, then goes to MEMWB.
- MEMWB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0. Goes to FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Stays until `mem_done`, then goes to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=RTYPE. Goes to RWB.
- RWB: `RegWrite`=1, `RegDst`=1, `MemToReg`=0. Goes to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=SUB, `PCWriteCond`=1, `PCSource`=01. Goes to FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10. Goes to FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=ADD. Goes to ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemToReg`=0. Goes to FETCH.
- TRAP:
  - `IllegalOp`=1 and all other controls 0.
  - The FSM stays in TRAP until reset.

## Timing
- Reset:
  - While `rst_n`=0, all outputs are 0 (gated by `rst_n`), `State`=FETCH, and the counter is 0.
  - The first rising edge after release runs a FETCH cycle.
- Reset asserted mid-instruction:
  - FSM returns to FETCH immediately (asynchronously).
  - Any pending `MemWrite`/`RegWrite` drops in the same cycle.
- Instruction latency, with the memory state completing in its first cycle:
  - lw = 5 cycles, sw = 4, R-type = 4, addi = 4, beq = 3, j = 3.
  - Each memory state adds (wait cycles − 1).
- `MemRead`/`MemWrite` stay asserted and stable for the entire wait.
- `IRWrite`/`PCWrite` in FETCH are a 1-cycle pulse, on the `mem_done` cycle only.
- `MemReady` high outside a memory state is ignored.
- `MemReady` high on the first cycle of a memory state completes that state in 1 cycle.
- `Opcode` changes outside DECODE have no effect.

## Test plan
- Reset and fetch handshake: `USE_MEM_READY`=1, hold `MemReady`=0 for 3 cycles then 1.
  - FETCH lasts 4 cycles with `MemRead`=1 throughout.
  - `IRWrite`=`PCWrite`=1 only on cycle 4; `State` then = 1.
- lw at `MEM_LATENCY`=3, `USE_MEM_READY`=0, opcode 100011.
  - State sequence 0,0,0,1,2,3,3,3,4,0.
  - `RegWrite`=`MemToReg`=1 only in state 4.
- One instruction of each type at latency 1: R-type, sw, beq, j, addi.
  - Cycle counts 4/4/3/3/4.
  - Check per-state controls: R-type `ALUOp`=4'b1000 in EXEC; beq `ALUOp`=4'b0110 and `PCWriteCond`=1 in BRANCH; j `PCSource`=10 in JUMP.
- Illegal opcode 111111 in DECODE.
  - FSM goes to `State`=12 with `IllegalOp`=1, held 20 cycles regardless of inputs.
  - `rst_n` pulse → `State`=0 and `IllegalOp`=0.
- Async reset in MEMWR with `MemWrite`=1.
  - Drop `rst_n` between clock edges → `MemWrite`=0 and `State`=0 without waiting for a clock edge.
- `Opcode` toggled during FETCH and MEMRD.
  - Path is still chosen by the value sampled in DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode, execute,
// memory and writeback over a shared ALU and a single memory port.
module multicycle_control #(
  parameter int                  OP_W          = 6,
  parameter int                  ALUOP_W       = 4,
  parameter logic [ALUOP_W-1:0]  ALUOP_ADD     = 4'b0010,
  parameter logic [ALUOP_W-1:0]  ALUOP_SUB     = 4'b0110,
  parameter logic [ALUOP_W-1:0]  ALUOP_RTYPE   = 4'b1000,
  parameter bit                  USE_MEM_READY = 1'b1,
  parameter int                  MEM_LATENCY   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Opcode,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemToReg,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               IllegalOp,
  output logic [3:0]         State
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_done;
  logic              is_mem_state;
  logic              zero_unused;

  // The branch decision is made in the datapath from Zero and PCWriteCond.
  assign zero_unused = Zero;

  always_comb begin
    if (USE_MEM_READY) begin
      mem_done = MemReady;
    end else begin
      mem_done = (cnt_q == CNT_LAST);
    end
  end

  assign is_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = '0;
    // Counter runs only while waiting inside a memory state; any exit clears it.
    if (!USE_MEM_READY && is_mem_state && !mem_done) begin
      cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls decode from the state register; rst_n gates them so pending
  // writes drop the moment reset asserts.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = '0;
    IllegalOp   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALUOP_ADD;
        IRWrite = mem_done;
        PCWrite = mem_done;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_RTYPE;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_TRAP:   IllegalOp = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemToReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUOp       = '0;
      IllegalOp   = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one ready-handshake instance and one
// fixed-latency (3-cycle) instance share clock, reset and opcode.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero_in;
  logic       mr1, mr3;

  logic       pcw1, pcwc1, iord1, mrd1, mwr1, mtr1, irw1, rw1, rd1, asa1, ill1;
  logic [1:0] asb1, pcs1;
  logic [3:0] aluop1, st1;
  logic       pcw3, pcwc3, iord3, mrd3, mwr3, mtr3, irw3, rw3, rd3, asa3, ill3;
  logic [1:0] asb3, pcs3;
  logic [3:0] aluop3, st3;

  logic [18:0] ctrl1, ctrl3;
  assign ctrl1 = {pcw1, pcwc1, iord1, mrd1, mwr1, mtr1, irw1, rw1, rd1, asa1,
                  asb1, pcs1, aluop1, ill1};
  assign ctrl3 = {pcw3, pcwc3, iord3, mrd3, mwr3, mtr3, irw3, rw3, rd3, asa3,
                  asb3, pcs3, aluop3, ill3};

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,RegWrite,RegDst,ALUSrcA},
  // ALUSrcB, PCSource, ALUOp, IllegalOp
  localparam logic [18:0] C_ZERO   = 19'b0;
  localparam logic [18:0] C_FETCH  = {10'b0001000000, 2'b01, 2'b00, 4'b0010, 1'b0};
  localparam logic [18:0] C_FDONE  = {10'b1001001000, 2'b01, 2'b00, 4'b0010, 1'b0};
  localparam logic [18:0] C_DECODE = {10'b0000000000, 2'b11, 2'b00, 4'b0010, 1'b0};
  localparam logic [18:0] C_MEMADR = {10'b0000000001, 2'b10, 2'b00, 4'b0010, 1'b0};
  localparam logic [18:0] C_MEMRD  = {10'b0011000000, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [18:0] C_MEMWB  = {10'b0000010100, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [18:0] C_MEMWR  = {10'b0010100000, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [18:0] C_EXEC   = {10'b0000000001, 2'b00, 2'b00, 4'b1000, 1'b0};
  localparam logic [18:0] C_RWB    = {10'b0000000110, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [18:0] C_BRANCH = {10'b0100000001, 2'b00, 2'b01, 4'b0110, 1'b0};
  localparam logic [18:0] C_JUMP   = {10'b1000000000, 2'b00, 2'b10, 4'b0000, 1'b0};
  localparam logic [18:0] C_ADDIWB = {10'b0000000100, 2'b00, 2'b00, 4'b0000, 1'b0};
  localparam logic [18:0] C_TRAP   = {18'b0, 1'b1};

  int errors = 0;
  int checks = 0;

  multicycle_control #(.USE_MEM_READY(1'b1), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Zero(zero_in), .MemReady(mr1),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mrd1),
    .MemWrite(mwr1), .MemToReg(mtr1), .IRWrite(irw1), .RegWrite(rw1),
    .RegDst(rd1), .ALUSrcA(asa1), .ALUSrcB(asb1), .PCSource(pcs1),
    .ALUOp(aluop1), .IllegalOp(ill1), .State(st1)
  );

  multicycle_control #(.USE_MEM_READY(1'b0), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .Opcode(opcode), .Zero(zero_in), .MemReady(mr3),
    .PCWrite(pcw3), .PCWriteCond(pcwc3), .IorD(iord3), .MemRead(mrd3),
    .MemWrite(mwr3), .MemToReg(mtr3), .IRWrite(irw3), .RegWrite(rw3),
    .RegDst(rd3), .ALUSrcA(asa3), .ALUSrcB(asb3), .PCSource(pcs3),
    .ALUOp(aluop3), .IllegalOp(ill3), .State(st3)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at a falling edge with reset just released; the following
  // rising edge evaluates the first FETCH cycle.
  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    mr1    = 1'b0;
    mr3    = 1'b0;
    opcode = 6'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    mr1    = 1'b1;
    mr3    = 1'b1;
    opcode = 6'b111111;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ctrl1 !== C_ZERO || st1 !== 4'd0) begin
        errors++;
        $display("FAIL reset_rdy[%0d]: state=%0d ctrl=%h, required state=0 ctrl=%h", k, st1, ctrl1, C_ZERO);
      end
      checks++;
      if (ctrl3 !== C_ZERO || st3 !== 4'd0) begin
        errors++;
        $display("FAIL reset_lat[%0d]: state=%0d ctrl=%h, required state=0 ctrl=%h", k, st3, ctrl3, C_ZERO);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_fetch_handshake();
    logic [3:0]  es [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd6};
    logic [18:0] ec [6] = '{C_FETCH, C_FETCH, C_FETCH, C_FDONE, C_DECODE, C_EXEC};
    logic        mv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    opcode = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      mr1 = mv[i];
      #1;
      checks++;
      if (st1 !== es[i]) begin
        errors++;
        $display("FAIL fetch_hs state cyc%0d: got %0d, required %0d", i, st1, es[i]);
      end
      checks++;
      if (ctrl1 !== ec[i]) begin
        errors++;
        $display("FAIL fetch_hs ctrl cyc%0d: got %h, required %h", i, ctrl1, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_latency3();
    logic [3:0]  es [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [18:0] ec [10] = '{C_FETCH, C_FETCH, C_FDONE, C_DECODE, C_MEMADR,
                             C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH};
    apply_reset();
    opcode = 6'b100011;
    for (int i = 0; i < 10; i++) begin
      mr3 = 1'b0;
      #1;
      checks++;
      if (st3 !== es[i]) begin
        errors++;
        $display("FAIL lw_lat3 state cyc%0d: got %0d, required %0d", i, st3, es[i]);
      end
      checks++;
      if (ctrl3 !== ec[i]) begin
        errors++;
        $display("FAIL lw_lat3 ctrl cyc%0d: got %h, required %h", i, ctrl3, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_instr_latency1();
    logic [5:0]  ops  [6] = '{6'b100011, 6'b000000, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    int          lens [6] = '{6, 5, 5, 4, 4, 5};
    logic [3:0]  es   [6][6];
    logic [18:0] ec   [6][6];
    es[0] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    ec[0] = '{C_FDONE, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FDONE};
    es[1] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0};
    ec[1] = '{C_FDONE, C_DECODE, C_EXEC, C_RWB, C_FDONE, C_ZERO};
    es[2] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0};
    ec[2] = '{C_FDONE, C_DECODE, C_MEMADR, C_MEMWR, C_FDONE, C_ZERO};
    es[3] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0};
    ec[3] = '{C_FDONE, C_DECODE, C_BRANCH, C_FDONE, C_ZERO, C_ZERO};
    es[4] = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 4'd0};
    ec[4] = '{C_FDONE, C_DECODE, C_JUMP, C_FDONE, C_ZERO, C_ZERO};
    es[5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd0, 4'd0};
    ec[5] = '{C_FDONE, C_DECODE, C_MEMADR, C_ADDIWB, C_FDONE, C_ZERO};
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      opcode = ops[r];
      for (int i = 0; i < lens[r]; i++) begin
        mr1 = 1'b1;
        #1;
        checks++;
        if (st1 !== es[r][i]) begin
          errors++;
          $display("FAIL instr op=%b state cyc%0d: got %0d, required %0d", ops[r], i, st1, es[r][i]);
        end
        checks++;
        if (ctrl1 !== ec[r][i]) begin
          errors++;
          $display("FAIL instr op=%b ctrl cyc%0d: got %h, required %h", ops[r], i, ctrl1, ec[r][i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_illegal_trap();
    apply_reset();
    opcode = 6'b111111;
    mr1 = 1'b1;
    #1;
    checks++;
    if (st1 !== 4'd0 || ctrl1 !== C_FDONE) begin
      errors++;
      $display("FAIL trap_fetch: state=%0d ctrl=%h, required state=0 ctrl=%h", st1, ctrl1, C_FDONE);
    end
    @(negedge clk);
    #1;
    checks++;
    if (st1 !== 4'd1 || ctrl1 !== C_DECODE) begin
      errors++;
      $display("FAIL trap_decode: state=%0d ctrl=%h, required state=1 ctrl=%h", st1, ctrl1, C_DECODE);
    end
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      mr1    = 1'($urandom_range(0, 1));
      opcode = 6'($urandom_range(0, 63));
      #1;
      checks++;
      if (st1 !== 4'd12 || ctrl1 !== C_TRAP) begin
        errors++;
        $display("FAIL trap_hold[%0d]: state=%0d ctrl=%h, required state=12 ctrl=%h", i, st1, ctrl1, C_TRAP);
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (st1 !== 4'd0 || ill1 !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset_low: state=%0d IllegalOp=%b, required state=0 IllegalOp=0", st1, ill1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mr1   = 1'b0;
    #1;
    checks++;
    if (st1 !== 4'd0 || ctrl1 !== C_FETCH) begin
      errors++;
      $display("FAIL trap_after_reset: state=%0d ctrl=%h, required state=0 ctrl=%h", st1, ctrl1, C_FETCH);
    end
  endtask

  task automatic test_async_reset_memwr();
    apply_reset();
    opcode = 6'b101011;
    mr1 = 1'b1;
    @(negedge clk);
    mr1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (st1 !== 4'd5 || ctrl1 !== C_MEMWR) begin
      errors++;
      $display("FAIL memwr_wait: state=%0d ctrl=%h, required state=5 ctrl=%h", st1, ctrl1, C_MEMWR);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mwr1 !== 1'b0 || st1 !== 4'd0 || ctrl1 !== C_ZERO) begin
      errors++;
      $display("FAIL async_reset: MemWrite=%b state=%0d ctrl=%h, required MemWrite=0 state=0 ctrl=%h",
               mwr1, st1, ctrl1, C_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_opcode_toggle();
    logic [5:0]  ov [10] = '{6'b000010, 6'b111111, 6'b000100, 6'b100011, 6'b101011,
                             6'b101011, 6'b000000, 6'b111111, 6'b000010, 6'b101011};
    logic [3:0]  es [10] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [18:0] ec [10] = '{C_FETCH, C_FETCH, C_FDONE, C_DECODE, C_MEMADR,
                             C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      opcode = ov[i];
      mr3    = 1'b1;
      #1;
      checks++;
      if (st3 !== es[i]) begin
        errors++;
        $display("FAIL op_toggle state cyc%0d: got %0d, required %0d", i, st3, es[i]);
      end
      checks++;
      if (ctrl3 !== ec[i]) begin
        errors++;
        $display("FAIL op_toggle ctrl cyc%0d: got %h, required %h", i, ctrl3, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = 6'b0;
    zero_in = 1'b0;
    mr1     = 1'b0;
    mr3     = 1'b0;
    test_reset();
    test_fetch_handshake();
    test_lw_latency3();
    test_instr_latency1();
    test_illegal_trap();
    test_async_reset_memwr();
    test_opcode_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
